// File: rtl/exmem_skid_pipe_reg_pkg.sv
// Shared types and helpers for the execute->memory pipeline register.
// Payload structs use the default core widths; the RTL datapath itself packs by parameter.
package exmem_pkg;

  localparam int EXMEM_XLEN    = 32;
  localparam int EXMEM_RADDR_W = 5;
  localparam int EXMEM_RSRC_W  = 2;

  localparam logic [EXMEM_RSRC_W-1:0] RES_ALU = 2'd0;
  localparam logic [EXMEM_RSRC_W-1:0] RES_MEM = 2'd1;
  localparam logic [EXMEM_RSRC_W-1:0] RES_PC4 = 2'd2;

  typedef struct packed {
    logic                    reg_write;
    logic                    mem_write;
    logic [EXMEM_RSRC_W-1:0] result_src;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [EXMEM_XLEN-1:0]    alu_result;
    logic [EXMEM_XLEN-1:0]    wr_data;
    logic [EXMEM_XLEN-1:0]    pc_plus4;
    logic [EXMEM_RADDR_W-1:0] rd_addr;
    exmem_ctrl_t              ctrl;
  } exmem_payload_t;

  function automatic int payload_width(input int xlen, input int raddr_w, input int rsrc_w);
    return 3 * xlen + raddr_w + 2 + rsrc_w;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/exmem_skid_pipe_reg_if.sv
// Valid/ready beat carrying one execute->memory payload; master drives valid and payload.
interface exmem_skid_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int RSRC_W  = 2
);
  logic               valid;
  logic               ready;
  logic [XLEN-1:0]    alu_result;
  logic [XLEN-1:0]    wr_data;
  logic [XLEN-1:0]    pc_plus4;
  logic [RADDR_W-1:0] rd_addr;
  logic               reg_write;
  logic               mem_write;
  logic [RSRC_W-1:0]  result_src;

  modport master (
    output valid, alu_result, wr_data, pc_plus4, rd_addr, reg_write, mem_write, result_src,
    input  ready
  );

  modport slave (
    input  valid, alu_result, wr_data, pc_plus4, rd_addr, reg_write, mem_write, result_src,
    output ready
  );
endinterface

// File: rtl/exmem_skid_pipe_reg_pipe_skid_buf.sv
// Generic 2-entry skid buffer (main + skid) with synchronous flush; in_ready comes
// straight from the skid valid flop, so there is no combinational ready path.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_r, skid_valid_r;
  logic [W-1:0] main_data_r, skid_data_r;
  logic         acc_s, drn_s;
  logic         main_valid_nxt_s, skid_valid_nxt_s;
  logic         main_load_s, skid_load_s;
  logic [W-1:0] main_data_nxt_s;

  assign in_ready  = !skid_valid_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_data_r;
  assign acc_s     = in_valid & !skid_valid_r;
  assign drn_s     = main_valid_r & out_ready;

  // Main refills from skid first (it is older); only then from the accepted input.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    main_load_s      = 1'b0;
    skid_load_s      = 1'b0;
    main_data_nxt_s  = in_data;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!main_valid_r || drn_s) begin
      if (skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
        main_load_s      = 1'b1;
        main_data_nxt_s  = skid_data_r;
      end else begin
        main_valid_nxt_s = acc_s;
        main_load_s      = acc_s;
        main_data_nxt_s  = in_data;
      end
    end else begin
      skid_valid_nxt_s = skid_valid_r | acc_s;
      skid_load_s      = acc_s;
    end
  end

  // Valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
    end
  end

  // Payload flops load only when their entry is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_r <= '0;
      skid_data_r <= '0;
    end else begin
      if (main_load_s) main_data_r <= main_data_nxt_s;
      if (skid_load_s) skid_data_r <= in_data;
    end
  end

endmodule

// File: rtl/exmem_skid_pipe_reg.sv
// Execute->memory pipeline register with valid/ready skid buffering and flush.
// Define EXMEM_PERF_CNT_EN to add saturating stall_cnt / bubble_cnt outputs.
module exmem_skid_pipe_reg
  import exmem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int RSRC_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  exmem_skid_pipe_reg_if.slave  in_bus,
  exmem_skid_pipe_reg_if.master out_bus
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           bubble_cnt
`endif
);

  localparam int PW = payload_width(XLEN, RADDR_W, RSRC_W);

  logic [PW-1:0] in_data_s, out_data_s;
  logic          out_valid_s, in_ready_s;
  logic          reg_write_s, mem_write_s;

  assign in_data_s = {in_bus.alu_result, in_bus.wr_data, in_bus.pc_plus4, in_bus.rd_addr,
                      in_bus.reg_write, in_bus.mem_write, in_bus.result_src};

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_bus.valid),
    .in_ready  (in_ready_s),
    .in_data   (in_data_s),
    .out_valid (out_valid_s),
    .out_ready (out_bus.ready),
    .out_data  (out_data_s)
  );

  assign in_bus.ready = in_ready_s;
  assign {out_bus.alu_result, out_bus.wr_data, out_bus.pc_plus4, out_bus.rd_addr,
          reg_write_s, mem_write_s, out_bus.result_src} = out_data_s;
  assign out_bus.valid = out_valid_s;
  // A bubble must never write the register file or memory
  assign out_bus.reg_write = reg_write_s & out_valid_s;
  assign out_bus.mem_write = mem_write_s & out_valid_s;

`ifdef EXMEM_PERF_CNT_EN
  // Stall and bubble counters: cleared by flush, saturate instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else if (flush) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      stall_cnt  <= sat_inc32(stall_cnt, out_valid_s & !out_bus.ready);
      bubble_cnt <= sat_inc32(bubble_cnt, !out_valid_s);
    end
  end
`endif

endmodule
